bcd_converter_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It takes BIN_W-bit unsigned values over a valid/ready handshake and returns DIGITS packed BCD digits, plus an overflow flag and, optionally, a leading-zero blank mask. It sits between the score/credit counters of the slot datapath and the seven-segment display drivers, and replaces the fixed 7-bit, 2-digit combinational converter.

---
 rtl/bcd_pkg.sv | 28 ++
 rtl/bcd_digit_adj.sv | 20 ++
 rtl/bcd_converter_seq.sv | 150 +++++++++++++++
 tb/tb_bcd_converter_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, the converter state encoding and a sizing helper
// for the sequential double-dabble binary-to-BCD converter.
// Optional feature macro used by the converter: BCD_LEADING_ZERO_BLANK_EN.
package bcd_pkg;

    // Width of one packed BCD digit.
    localparam int DIGIT_W    = 4;

    // Double-dabble correction: a digit at or above ADJ_THRESH gets ADJ_ADD
    // added before the shift, so that doubling it carries correctly into the
    // next decimal digit.
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

    // Converter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Bit-counter width. The counter must be able to hold BIN_W itself,
    // because it is loaded with BIN_W and counts down to 1.
    function automatic int cnt_width(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational add-3-if-at-least-5 correction for one BCD
// digit. A digit reaching this block is never above 9, so the result never
// exceeds 12 and always fits in 4 bits.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adj
);

    // Pre-shift correction so that doubling the digit produces a decimal carry.
    always_comb begin
        if (digit >= DIGIT_W'(ADJ_THRESH)) begin
            adj = digit + DIGIT_W'(ADJ_ADD);
        end else begin
            adj = digit;
        end
    end

endmodule

// File: rtl/bcd_converter_seq.sv
// bcd_converter_seq: sequential binary-to-BCD converter using shift-and-add-3
// (double dabble), one input bit per clock, behind valid/ready handshakes.
//
// A value is accepted in IDLE, shifted for BIN_W cycles in SHIFT, and then
// held in DONE until the consumer takes it. The accumulator is exactly
// DIGITS digits wide; any bit pushed out of the top digit marks overflow, in
// which case out_bcd carries only the low DIGITS decimal digits.
//
// Optional feature macro: BCD_LEADING_ZERO_BLANK_EN.
//   defined   - out_blank carries a registered leading-zero mask for the
//               result (digit 0 is never blanked).
//   undefined - out_blank is tied to zero and no blanking logic exists.
module bcd_converter_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          in_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                      out_ovf,
    output logic [DIGITS-1:0]         out_blank
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_width(BIN_W);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_SHIFT = 2'(SHIFT);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    logic [1:0]       state;
    logic [BIN_W-1:0] bin_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] acc_next;
    logic             shift_out;
    logic             accept;
    logic             last_shift;

    assign accept     = (state == ST_IDLE) && in_valid;
    assign last_shift = (state == ST_SHIFT) && (cnt_q == CNT_LAST);

    // Every digit is corrected in parallel; there is no carry between digits
    // because each correction result stays within its own 4 bits.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (acc_q  [g*DIGIT_W +: DIGIT_W]),
            .adj   (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // One double-dabble step: the corrected accumulator shifts left, the next
    // binary MSB enters the units digit, and the top bit falls out as overflow.
    always_comb begin
        acc_next  = {acc_adj[ACC_W-2:0], bin_q[BIN_W-1]};
        shift_out = acc_adj[ACC_W-1];
    end

    // Sequencer and datapath registers: load on accept, shift BIN_W times,
    // then hold the result until the consumer pops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            bin_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        bin_q <= in_bin;
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                        cnt_q <= CNT_LOAD;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc_q <= acc_next;
                    bin_q <= bin_q << 1;
                    ovf_q <= ovf_q | shift_out;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_bcd   = acc_q;
    assign out_ovf   = ovf_q;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_q;
    logic              zero_run;

    // Leading-zero mask of the final accumulator value: a digit is blanked
    // only while every digit above it is also zero; the units digit never is.
    always_comb begin
        blank_next = '0;
        zero_run   = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run      = zero_run && (acc_next[k*DIGIT_W +: DIGIT_W] == '0);
            blank_next[k] = zero_run;
        end
    end

    // The mask is captured on the final shift so it enters DONE alongside out_bcd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else if (accept) begin
            blank_q <= '0;
        end else if (last_shift) begin
            blank_q <= blank_next;
        end
    end

    assign out_blank = blank_q;
`else
    assign out_blank = '0;
`endif

endmodule

// File: tb/tb_bcd_converter_seq.sv
// tb_bcd_converter_seq: directed self-checking bench for bcd_converter_seq.
// A 5-digit instance covers the main cases; a 4-digit instance covers
// overflow. Blank-mask expectations follow BCD_LEADING_ZERO_BLANK_EN.
module tb_bcd_converter_seq;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    localparam int BIN_W = 14;
    localparam int LAT   = BIN_W + 1;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [13:0] in_bin;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] out_bcd;
    logic        out_ovf;
    logic [4:0]  out_blank;

    logic        in_valid4;
    logic        in_ready4;
    logic [13:0] in_bin4;
    logic        out_valid4;
    logic        out_ready4;
    logic [15:0] out_bcd4;
    logic        out_ovf4;
    logic [3:0]  out_blank4;

    int testsRun;
    int testsFailed;

    bcd_converter_seq #(.BIN_W(14), .DIGITS(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ovf   (out_ovf),
        .out_blank (out_blank)
    );

    bcd_converter_seq #(.BIN_W(14), .DIGITS(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_bin    (in_bin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_bcd   (out_bcd4),
        .out_ovf   (out_ovf4),
        .out_blank (out_blank4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] expBlank5(input logic [4:0] onVal);
        return BLANK_ON ? onVal : 5'b00000;
    endfunction

    function automatic logic [3:0] expBlank4(input logic [3:0] onVal);
        return BLANK_ON ? onVal : 4'b0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Start a conversion on the 5-digit instance and wait (bounded) for DONE.
    task automatic applyStimulus(input logic [13:0] value, output int latency);
        @(negedge clk);
        out_ready = 1'b0;
        in_bin    = value;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        latency = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (!out_valid && latency < 100);
    endtask

    task automatic applyStimulus4(input logic [13:0] value, output int latency);
        @(negedge clk);
        out_ready4 = 1'b0;
        in_bin4    = value;
        in_valid4  = 1'b1;
        @(posedge clk);
        #1 in_valid4 = 1'b0;
        latency = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (!out_valid4 && latency < 100);
    endtask

    task automatic popResult(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ready_after_pop"}, in_ready, 1);
        checkOutput({tag, "_valid_after_pop"}, out_valid, 0);
    endtask

    task automatic popResult4(input string tag);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1 out_ready4 = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_ready_after_pop"}, in_ready4, 1);
    endtask

    initial begin
        int           lat;
        int           idx;
        int           cyc;
        int           nres;
        bit           stable;
        logic [13:0]  vals [3];
        logic [19:0]  expBcd [3];
        logic [4:0]   expBlk [3];
        logic [19:0]  resBcd [3];
        logic [4:0]   resBlk [3];
        int           resCyc [3];

        testsRun    = 0;
        testsFailed = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bin      = '0;
        out_ready   = 1'b0;
        in_valid4   = 1'b0;
        in_bin4     = '0;
        out_ready4  = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_in_ready",  in_ready,  1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_bcd",   out_bcd,   0);
        checkOutput("rst_out_ovf",   out_ovf,   0);
        checkOutput("rst_out_blank", out_blank, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Largest 14-bit value
        applyStimulus(14'd16383, lat);
        checkOutput("max_latency", lat, LAT);
        checkOutput("max_bcd",     out_bcd,   20'h16383);
        checkOutput("max_ovf",     out_ovf,   0);
        checkOutput("max_blank",   out_blank, expBlank5(5'b00000));
        checkOutput("max_busy",    in_ready,  0);
        popResult("max");

        // Zero
        applyStimulus(14'd0, lat);
        checkOutput("zero_bcd",   out_bcd,   20'h00000);
        checkOutput("zero_ovf",   out_ovf,   0);
        checkOutput("zero_blank", out_blank, expBlank5(5'b11110));
        popResult("zero");

        // Four-digit instance: overflow, then the largest representable value
        applyStimulus4(14'd10000, lat);
        checkOutput("ovf_latency", lat, LAT);
        checkOutput("ovf_flag",    out_ovf4,   1);
        checkOutput("ovf_bcd",     out_bcd4,   16'h0000);
        checkOutput("ovf_blank",   out_blank4, expBlank4(4'b1110));
        popResult4("ovf");
        applyStimulus4(14'd9999, lat);
        checkOutput("d4max_bcd",   out_bcd4,   16'h9999);
        checkOutput("d4max_ovf",   out_ovf4,   0);
        checkOutput("d4max_blank", out_blank4, expBlank4(4'b0000));
        popResult4("d4max");

        // Backpressure: result held for 20 cycles, extra in_valid ignored
        applyStimulus(14'd42, lat);
        stable = 1'b1;
        in_bin   = 14'd99;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_bcd !== 20'h00042 || in_ready !== 1'b0 || out_valid !== 1'b1)
                stable = 1'b0;
        end
        in_valid = 1'b0;
        checkOutput("bp_held_stable", stable,    1);
        checkOutput("bp_bcd",         out_bcd,   20'h00042);
        checkOutput("bp_blank",       out_blank, expBlank5(5'b11100));
        popResult("bp");

        // Back-to-back with out_ready held high
        vals[0] = 14'd1;   expBcd[0] = 20'h00001; expBlk[0] = 5'b11110;
        vals[1] = 14'd10;  expBcd[1] = 20'h00010; expBlk[1] = 5'b11100;
        vals[2] = 14'd255; expBcd[2] = 20'h00255; expBlk[2] = 5'b11000;
        @(negedge clk);
        out_ready = 1'b1;
        idx  = 0;
        cyc  = 0;
        nres = 0;
        while (nres < 3 && cyc < 200) begin
            if (out_valid) begin
                resBcd[nres] = out_bcd;
                resBlk[nres] = out_blank;
                resCyc[nres] = cyc;
                nres++;
            end
            if (in_ready && idx < 3) begin
                in_bin   = vals[idx];
                in_valid = 1'b1;
                idx++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput("b2b_count", nres, 3);
        for (int i = 0; i < 3; i++) begin
            if (i < nres) begin
                checkOutput($sformatf("b2b_bcd%0d", i), resBcd[i], expBcd[i]);
                checkOutput($sformatf("b2b_blank%0d", i), resBlk[i], expBlank5(expBlk[i]));
            end
        end
        if (nres == 3) begin
            checkOutput("b2b_gap01", resCyc[1] - resCyc[0], BIN_W + 2);
            checkOutput("b2b_gap12", resCyc[2] - resCyc[1], BIN_W + 2);
        end
        @(negedge clk);

        // Reset in the middle of SHIFT
        @(negedge clk);
        in_bin   = 14'd1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready",  in_ready,  1);
        checkOutput("midrst_out_valid", out_valid, 0);
        checkOutput("midrst_out_bcd",   out_bcd,   0);
        checkOutput("midrst_out_ovf",   out_ovf,   0);
        checkOutput("midrst_out_blank", out_blank, 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(14'd77, lat);
        checkOutput("post_rst_latency", lat, LAT);
        checkOutput("post_rst_bcd",     out_bcd,   20'h00077);
        checkOutput("post_rst_ovf",     out_ovf,   0);
        checkOutput("post_rst_blank",   out_blank, expBlank5(5'b11100));
        popResult("post_rst");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
